// File: rtl/ysyx_24100005_ifu.sv
// ysyx_24100005_ifu: multi-cycle instruction fetch unit.
// One request in flight; redirects squash or retarget fetches.
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic        redir_pend;
    logic [31:0] redir_pc;
    logic [31:0] data_q;
    logic        err_q;
    logic        req_v_q;
    logic        inst_v_q;
    logic [31:0] redir_tgt;

    // Redirect target with the low address bits forced to zero
    assign redir_tgt = redirect_pc & ~32'h3;

    assign mem_req_valid = req_v_q;
    assign mem_req_addr  = pc;
    assign inst_valid    = inst_v_q;
    assign inst_data     = data_q;
    assign inst_pc       = pc;
    assign inst_err      = err_q;

    // Fetch FSM with registered valid flags and held instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            redir_pend <= 1'b0;
            redir_pc   <= RESET_PC;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
            req_v_q    <= 1'b0;
            inst_v_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state   <= REQ;
                    req_v_q <= 1'b1;
                end
                REQ: begin
                    if (redirect_valid) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= redir_tgt;
                    end
                    if (mem_req_ready) begin
                        state   <= WAIT;
                        req_v_q <= 1'b0;
                        if (redirect_valid) begin
                            drop <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (drop || redir_pend || redirect_valid) begin
                            pc         <= redirect_valid ? redir_tgt : redir_pc;
                            drop       <= 1'b0;
                            redir_pend <= 1'b0;
                            state      <= REQ;
                            req_v_q    <= 1'b1;
                        end else begin
                            data_q   <= mem_rsp_data;
                            err_q    <= mem_rsp_err;
                            state    <= HOLD;
                            inst_v_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= redir_tgt;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc       <= redir_tgt;
                        state    <= REQ;
                        req_v_q  <= 1'b1;
                        inst_v_q <= 1'b0;
                    end else if (inst_ready) begin
                        pc       <= pc + 32'd4;
                        state    <= REQ;
                        req_v_q  <= 1'b1;
                        inst_v_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    req_v_q  <= 1'b0;
                    inst_v_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// tb_ysyx_24100005_ifu: directed bench for the fetch unit.
// Behavioural memory returns addr ^ 32'h1234_5678.
module tb_ysyx_24100005_ifu;

    localparam logic [31:0] K = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    logic err_en = 1'b0;
    int cnt = 0;
    int cons = 0;
    logic [31:0] rsp_a = 32'h0;
    logic [31:0] addr_q[$];

    ysyx_24100005_ifu dut (
        .clk(clk),
        .rst(rst),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .inst_err(inst_err),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory model: response lat cycles after the accepting edge
    always @(posedge clk) begin
        logic        hs;
        logic [31:0] a;
        hs = mem_req_valid && mem_req_ready && !rst;
        a  = mem_req_addr;
        if (inst_valid && inst_ready && !rst) cons++;
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (hs) begin
                cnt   = lat;
                rsp_a = a;
                addr_q.push_back(a);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rsp_a ^ K;
                    mem_rsp_err   = err_en;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_reqv"}, {31'h0, mem_req_valid}, 32'h0);
        check({tag, "_addr"}, mem_req_addr, 32'h8000_0000);
        check({tag, "_iv"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_data"}, inst_data, 32'h0);
        check({tag, "_pc"}, inst_pc, 32'h8000_0000);
        check({tag, "_err"}, {31'h0, inst_err}, 32'h0);
    endtask

    task automatic wait_hold(input string tag, input logic [31:0] pc,
                             input logic err);
        int n = 0;
        do begin
            step();
            n++;
        end while (!inst_valid && n < 20);
        check({tag, "_iv"}, {31'h0, inst_valid}, 32'h1);
        check({tag, "_pc"}, inst_pc, pc);
        check({tag, "_data"}, inst_data, pc ^ K);
        check({tag, "_err"}, {31'h0, inst_err}, {31'h0, err});
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'h0;
        mem_rsp_err = 1'b0;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        check_reset("rst0");
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            logic [31:0] ep;
            ep = 32'h8000_0000 + 32'((k / 3 - 1) * 4);
            check($sformatf("seq_iv%0d", k), {31'h0, inst_valid},
                  {31'h0, (k == 3 || k == 6 || k == 9)});
            if (k == 3 || k == 6 || k == 9) begin
                check($sformatf("seq_pc%0d", k), inst_pc, ep);
                check($sformatf("seq_data%0d", k), inst_data, ep ^ K);
            end
            if (k == 9) inst_ready = 1'b0;
            step();
        end
        check("seq_nreq", addr_q.size(), 32'd3);
        check("seq_a0", addr_q[0], 32'h8000_0000);
        check("seq_a1", addr_q[1], 32'h8000_0004);
        check("seq_a2", addr_q[2], 32'h8000_0008);

        for (int i = 0; i < 5; i++) begin
            check("bp_iv", {31'h0, inst_valid}, 32'h1);
            check("bp_pc", inst_pc, 32'h8000_0008);
            check("bp_data", inst_data, 32'h8000_0008 ^ K);
            check("bp_reqv", {31'h0, mem_req_valid}, 32'h0);
            step();
        end
        check("bp_nreq", addr_q.size(), 32'd3);
        inst_ready = 1'b1;
        step();
        check("bp_reqv2", {31'h0, mem_req_valid}, 32'h1);
        check("bp_addr", mem_req_addr, 32'h8000_000C);

        lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        check("rw_iv1", {31'h0, inst_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
        check("rw_iv2", {31'h0, inst_valid}, 32'h0);
        step();
        check("rw_iv3", {31'h0, inst_valid}, 32'h0);
        lat = 1;
        step();
        check("rw_reqv", {31'h0, mem_req_valid}, 32'h1);
        check("rw_addr", mem_req_addr, 32'h8000_0100);
        wait_hold("rw_h", 32'h8000_0100, 1'b0);

        mem_req_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("rs_reqv", {31'h0, mem_req_valid}, 32'h1);
            check("rs_addr", mem_req_addr, 32'h8000_0104);
            redirect_valid = (i == 1);
            redirect_pc = 32'h8000_0200;
            if (i == 4) mem_req_ready = 1'b1;
            step();
        end
        check("rs_iv", {31'h0, inst_valid}, 32'h0);
        step();
        check("rs_reqv2", {31'h0, mem_req_valid}, 32'h1);
        check("rs_addr2", mem_req_addr, 32'h8000_0200);
        wait_hold("rs_h", 32'h8000_0200, 1'b0);

        c0 = cons;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        step();
        redirect_valid = 1'b0;
        check("rh_cons", cons, c0 + 1);
        check("rh_reqv", {31'h0, mem_req_valid}, 32'h1);
        check("rh_addr", mem_req_addr, 32'h8000_0040);
        check("rh_iv", {31'h0, inst_valid}, 32'h0);
        wait_hold("rh_h", 32'h8000_0040, 1'b0);

        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        err_en = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("wr_addr", mem_req_addr, 32'hFFFF_FFFC);
        wait_hold("wr_h", 32'hFFFF_FFFC, 1'b1);
        err_en = 1'b0;
        step();
        check("wr_reqv", {31'h0, mem_req_valid}, 32'h1);
        check("wr_wrap", mem_req_addr, 32'h0);
        lat = 3;
        step();
        rst = 1'b1;
        step();
        check_reset("rst1");
        rst = 1'b0;
        lat = 1;
        step();
        check("rr_reqv", {31'h0, mem_req_valid}, 32'h1);
        check("rr_addr", mem_req_addr, 32'h8000_0000);
        wait_hold("rr_h", 32'h8000_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
